// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default widths and timing helpers.
package uart_pkg;

  localparam int UART_DATA_WIDTH           = 8;
  localparam int UART_CLKS_PER_BIT_DEFAULT = 434;

  // Receiver FSM states; XX gives X-propagation on an illegal encoding in simulation.
  typedef enum logic [2:0] {
    IDLE     = 3'd1,
    RX_START = 3'd2,
    RX_DATA  = 3'd3,
    RX_STOP  = 3'd4,
    RX_BREAK = 3'd5,
    XX       = 3'bxxx
  } state_e;

  // Transmitter FSM states, shared with the Uart_Tx side of the link.
  typedef enum logic [2:0] {
    TX_IDLE  = 3'd1,
    TX_START = 3'd2,
    TX_DATA  = 3'd3,
    TX_STOP  = 3'd4,
    TX_XX    = 3'bxxx
  } tx_state_e;

  // Clock count at which the start bit is at its centre.
  function automatic logic [31:0] mid_bit_count(input int clks_per_bit);
    mid_bit_count = 32'((clks_per_bit - 1) / 2);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Double-register the asynchronous input to settle metastability.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples each bit at its centre, reports good bytes and framing errors.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int DATA_WIDTH   = UART_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx_serial_in,
  output logic [DATA_WIDTH-1:0] rx_byte_out,
  output logic                  rx_valid,
  output logic                  rx_frame_err,
  output logic                  rx_active
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [31:0]      MID_COUNT  = mid_bit_count(CLKS_PER_BIT);
  localparam logic [31:0]      LAST_COUNT = 32'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO   = IDX_W'(0);

  logic                  rx_sync_s;
  state_e                state_r;
  state_e                next_state_s;
  logic [31:0]           clk_count_r;
  logic [IDX_W-1:0]      bit_index_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [DATA_WIDTH-1:0] rx_byte_out_r;
  logic                  rx_valid_r;
  logic                  rx_frame_err_r;
  logic                  rx_active_r;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx_serial_in),
    .q       (rx_sync_s)
  );

  // Next-state decode from the current state, bit timer and synchronized line.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!rx_sync_s) next_state_s = RX_START;
        else            next_state_s = IDLE;
      end
      RX_START: begin
        if (clk_count_r < MID_COUNT) next_state_s = RX_START;
        else if (!rx_sync_s)         next_state_s = RX_DATA;
        else                         next_state_s = IDLE;
      end
      RX_DATA: begin
        if (clk_count_r < LAST_COUNT)    next_state_s = RX_DATA;
        else if (bit_index_r < IDX_LAST) next_state_s = RX_DATA;
        else                             next_state_s = RX_STOP;
      end
      RX_STOP: begin
        if (clk_count_r < LAST_COUNT) next_state_s = RX_STOP;
        else if (rx_sync_s)           next_state_s = IDLE;
        else                          next_state_s = RX_BREAK;
      end
      RX_BREAK: begin
        if (rx_sync_s) next_state_s = IDLE;
        else           next_state_s = RX_BREAK;
      end
      default: next_state_s = XX;
    endcase
  end

  // State register plus bit timer, shift register and registered output pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      clk_count_r    <= 32'd0;
      bit_index_r    <= IDX_ZERO;
      shift_r        <= {DATA_WIDTH{1'b0}};
      rx_byte_out_r  <= {DATA_WIDTH{1'b0}};
      rx_valid_r     <= 1'b0;
      rx_frame_err_r <= 1'b0;
      rx_active_r    <= 1'b0;
    end else begin
      state_r        <= next_state_s;
      rx_valid_r     <= 1'b0;
      rx_frame_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          clk_count_r <= 32'd0;
          bit_index_r <= IDX_ZERO;
          rx_active_r <= 1'b0;
        end
        RX_START: begin
          bit_index_r <= IDX_ZERO;
          if (clk_count_r < MID_COUNT) begin
            clk_count_r <= clk_count_r + 32'd1;
          end else begin
            clk_count_r <= 32'd0;
            // A line that is high again at mid-bit was only a glitch.
            rx_active_r <= ~rx_sync_s;
          end
        end
        RX_DATA: begin
          if (clk_count_r < LAST_COUNT) begin
            clk_count_r <= clk_count_r + 32'd1;
          end else begin
            clk_count_r          <= 32'd0;
            shift_r[bit_index_r] <= rx_sync_s;
            if (bit_index_r < IDX_LAST) bit_index_r <= bit_index_r + IDX_ONE;
            else                        bit_index_r <= bit_index_r;
          end
        end
        RX_STOP: begin
          if (clk_count_r < LAST_COUNT) begin
            clk_count_r <= clk_count_r + 32'd1;
          end else begin
            clk_count_r <= 32'd0;
            if (rx_sync_s) begin
              rx_byte_out_r <= shift_r;
              rx_valid_r    <= 1'b1;
              rx_active_r   <= 1'b0;
            end else begin
              // Bad stop bit: keep the previous byte and report the error once.
              rx_frame_err_r <= 1'b1;
            end
          end
        end
        RX_BREAK: begin
          clk_count_r <= 32'd0;
          if (rx_sync_s) rx_active_r <= 1'b0;
          else           rx_active_r <= rx_active_r;
        end
        default: begin
          clk_count_r    <= {32{1'bx}};
          bit_index_r    <= {IDX_W{1'bx}};
          shift_r        <= {DATA_WIDTH{1'bx}};
          rx_byte_out_r  <= {DATA_WIDTH{1'bx}};
          rx_valid_r     <= 1'bx;
          rx_frame_err_r <= 1'bx;
          rx_active_r    <= 1'bx;
        end
      endcase
    end
  end

  assign rx_byte_out  = rx_byte_out_r;
  assign rx_valid     = rx_valid_r;
  assign rx_frame_err = rx_frame_err_r;
  assign rx_active    = rx_active_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one receiver at 16 clocks/bit, one at 434 clocks/bit.
module tb_uart_rx;

  localparam int CPB_S = 16;
  localparam int CPB_L = 434;
  localparam int LAT_L = 9 * CPB_L + (CPB_L - 1) / 2 + 4;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       line_s  = 1'b1;
  logic       line_l  = 1'b1;
  logic [7:0] byte_s, byte_l;
  logic       valid_s, valid_l, ferr_s, ferr_l, act_s, act_l;

  uart_rx #(.CLKS_PER_BIT(CPB_S), .DATA_WIDTH(8)) dut_s (
    .clk(clk), .reset_n(reset_n), .rx_serial_in(line_s), .rx_byte_out(byte_s),
    .rx_valid(valid_s), .rx_frame_err(ferr_s), .rx_active(act_s)
  );

  uart_rx #(.CLKS_PER_BIT(CPB_L), .DATA_WIDTH(8)) dut_l (
    .clk(clk), .reset_n(reset_n), .rx_serial_in(line_l), .rx_byte_out(byte_l),
    .rx_valid(valid_l), .rx_frame_err(ferr_l), .rx_active(act_l)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitors, sampled on the falling edge.
  int         nv_s = 0, ne_s = 0, nact_s = 0, nbad_s = 0;
  int         nv_l = 0, ne_l = 0, nbad_l = 0;
  logic       prev_s = 1'b0, prev_l = 1'b0;
  logic [7:0] q_s[$];
  logic [7:0] q_l[$];
  int         vt_l[$];
  int         st_l[$];

  // Record pulses, captured bytes and pulse-rule violations for the small receiver.
  always @(negedge clk) begin
    if (valid_s) begin
      nv_s <= nv_s + 1;
      q_s.push_back(byte_s);
    end
    if (ferr_s) ne_s <= ne_s + 1;
    if (act_s) nact_s <= nact_s + 1;
    if ((valid_s && ferr_s) || ((valid_s || ferr_s) && prev_s)) nbad_s <= nbad_s + 1;
    prev_s <= valid_s | ferr_s;
  end

  // Record pulses, bytes and arrival cycles for the full-rate receiver.
  always @(negedge clk) begin
    if (valid_l) begin
      nv_l <= nv_l + 1;
      q_l.push_back(byte_l);
      vt_l.push_back(cyc);
    end
    if (ferr_l) ne_l <= ne_l + 1;
    if ((valid_l && ferr_l) || ((valid_l || ferr_l) && prev_l)) nbad_l <= nbad_l + 1;
    prev_l <= valid_l | ferr_l;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input bit big, input logic v, input int n);
    if (big) line_l = v;
    else     line_s = v;
    repeat (n) @(negedge clk);
  endtask

  // Bit-level transmitter: start, 8 data bits LSB first, stop of chosen value/length.
  task automatic send_frame(input bit big, input logic [7:0] d, input logic stop_v, input int stop_n);
    int cpb;
    cpb = big ? CPB_L : CPB_S;
    if (big) st_l.push_back(cyc);
    drive(big, 1'b0, cpb);
    for (int i = 0; i < 8; i++) drive(big, d[i], cpb);
    drive(big, stop_v, stop_n);
  endtask

  logic [7:0] tbl_l [12] = '{8'h3A, 8'hC7, 8'h01, 8'h80, 8'hFE, 8'h55,
                             8'hAA, 8'h12, 8'hED, 8'h6B, 8'h94, 8'hF0};
  logic [7:0] exp_b2b [3] = '{8'h00, 8'hFF, 8'h5A};

  int b_v, b_e, b_a, b_q, lat;
  logic [31:0] got_w;

  initial begin
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_byte", {24'd0, byte_s}, 32'h00);
    check("rst_valid", {31'd0, valid_s}, 32'd0);
    check("rst_ferr", {31'd0, ferr_s}, 32'd0);
    check("rst_active", {31'd0, act_s}, 32'd0);
    check("rst_byte_l", {24'd0, byte_l}, 32'h00);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single loopback frame.
    b_v = nv_s; b_e = ne_s;
    send_frame(1'b0, 8'hA5, 1'b1, CPB_S);
    repeat (2 * CPB_S) @(negedge clk);
    check("a5_count", 32'(nv_s - b_v), 32'd1);
    check("a5_byte", {24'd0, byte_s}, 32'hA5);
    check("a5_ferr", 32'(ne_s - b_e), 32'd0);
    check("a5_idle_active", {31'd0, act_s}, 32'd0);

    // Back-to-back frames with no idle gap.
    b_v = nv_s; b_q = q_s.size();
    send_frame(1'b0, 8'h00, 1'b1, CPB_S);
    send_frame(1'b0, 8'hFF, 1'b1, CPB_S);
    send_frame(1'b0, 8'h5A, 1'b1, CPB_S);
    repeat (2 * CPB_S) @(negedge clk);
    check("b2b_count", 32'(nv_s - b_v), 32'd3);
    for (int i = 0; i < 3; i++) begin
      got_w = (b_q + i < q_s.size()) ? {24'd0, q_s[b_q + i]} : 32'hxxxxxxxx;
      check($sformatf("b2b_byte%0d", i), got_w, {24'd0, exp_b2b[i]});
    end

    // Short low glitch must be rejected without pulses or activity.
    b_v = nv_s; b_e = ne_s; b_a = nact_s;
    drive(1'b0, 1'b0, 4);
    drive(1'b0, 1'b1, 3 * CPB_S);
    check("glitch_valid", 32'(nv_s - b_v), 32'd0);
    check("glitch_ferr", 32'(ne_s - b_e), 32'd0);
    check("glitch_active", 32'(nact_s - b_a), 32'd0);
    send_frame(1'b0, 8'h96, 1'b1, CPB_S);
    repeat (2 * CPB_S) @(negedge clk);
    check("rearm_byte", {24'd0, byte_s}, 32'h96);

    // Stop bit held low: one framing error, byte kept, silent while line stays low.
    b_v = nv_s; b_e = ne_s;
    send_frame(1'b0, 8'h3C, 1'b0, 40);
    check("brk_ferr", 32'(ne_s - b_e), 32'd1);
    check("brk_valid", 32'(nv_s - b_v), 32'd0);
    check("brk_byte_kept", {24'd0, byte_s}, 32'h96);
    check("brk_active_low_line", {31'd0, act_s}, 32'd1);
    drive(1'b0, 1'b1, 2 * CPB_S);
    check("brk_active_after", {31'd0, act_s}, 32'd0);
    check("brk_ferr_total", 32'(ne_s - b_e), 32'd1);

    // Reset in the middle of bit 4 of 0x81, then a clean 0x7E.
    b_v = nv_s; b_e = ne_s;
    drive(1'b0, 1'b0, CPB_S);
    for (int i = 0; i < 4; i++) drive(1'b0, (i == 0) ? 1'b1 : 1'b0, CPB_S);
    drive(1'b0, 1'b0, CPB_S / 2);
    check("mid_active", {31'd0, act_s}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_byte", {24'd0, byte_s}, 32'h00);
    check("mid_rst_active", {31'd0, act_s}, 32'd0);
    check("mid_rst_valid", {31'd0, valid_s}, 32'd0);
    check("mid_rst_ferr", {31'd0, ferr_s}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    drive(1'b0, 1'b1, 2 * CPB_S);
    send_frame(1'b0, 8'h7E, 1'b1, CPB_S);
    repeat (2 * CPB_S) @(negedge clk);
    check("post_rst_count", 32'(nv_s - b_v), 32'd1);
    check("post_rst_byte", {24'd0, byte_s}, 32'h7E);
    check("post_rst_ferr", 32'(ne_s - b_e), 32'd0);

    // Full-rate stream with latency window check.
    b_q = q_l.size();
    for (int i = 0; i < 12; i++) send_frame(1'b1, tbl_l[i], 1'b1, CPB_L);
    repeat (2 * CPB_L) @(negedge clk);
    check("l_count", 32'(q_l.size() - b_q), 32'd12);
    check("l_ferr", 32'(ne_l), 32'd0);
    for (int i = 0; i < 12; i++) begin
      got_w = (b_q + i < q_l.size()) ? {24'd0, q_l[b_q + i]} : 32'hxxxxxxxx;
      check($sformatf("l_byte%0d", i), got_w, {24'd0, tbl_l[i]});
      lat = (b_q + i < vt_l.size()) ? (vt_l[b_q + i] - st_l[i]) : -1;
      if (lat < LAT_L - 1 || lat > LAT_L + 1) begin
        $display("FAIL l_lat%0d: latency %0d cycles, required %0d +/-1", i, lat, LAT_L);
      end
      check($sformatf("l_lat_ok%0d", i),
            {31'd0, (lat >= LAT_L - 1 && lat <= LAT_L + 1)}, 32'd1);
    end

    check("pulse_rules_s", 32'(nbad_s), 32'd0);
    check("pulse_rules_l", 32'(nbad_l), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
